// File: rtl/bin2dec_seq.sv
// bin2dec_seq
//
// Sequential binary-to-BCD digit splitter. An 8-bit unsigned value is divided
// by 10 twice with restoring division, one quotient bit per clock:
//   DIV1: din / 10     -> remainder is the ones digit, quotient feeds DIV2
//   DIV2: (din/10)/10  -> remainder is the tens digit, quotient is hundreds
// A conversion takes 16 clocks from the accepting edge to the done pulse.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     conversion request, sampled only while idle
//   din       8-bit unsigned value, captured on the accepting edge
//   busy      high while a conversion is in progress
//   done      one-cycle pulse, digits valid from this cycle onward
//   hundreds  BCD hundreds digit (0..2)
//   tens      BCD tens digit (0..9)
//   ones      BCD ones digit (0..9); updates 8 clocks before tens/hundreds,
//             so consumers must qualify the digits with done

module bin2dec_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV1 = 2'd1,
    DIV2 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0] a;       // dividend being consumed MSB first
  logic [7:0] q;       // quotient under construction
  logic [4:0] r;       // partial remainder, always < 10 between steps
  logic [2:0] cnt;     // step index 0..7 within one division

  logic [4:0] rs;      // shifted remainder, at most 19
  logic       ge;      // shifted remainder reaches the divisor
  logic [4:0] r_step;  // remainder after this step
  logic [7:0] q_step;  // quotient after this step
  logic       last;    // eighth step of the current division

  // One restoring-division step, shared by DIV1 and DIV2.
  // NOTE: every signal is assigned a default at the top of the always_comb
  // so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    rs             = {r[3:0], a[3'd7 - cnt]};
    ge             = (rs >= 5'd10);
    r_step         = ge ? (rs - 5'd10) : rs;
    q_step         = q;
    q_step[3'd7 - cnt] = ge;
    last           = (cnt == 3'd7);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = DIV1;
      DIV1: if (last)  state_next = DIV2;
      DIV2: if (last)  state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // in the design samples the pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath and output registers. All of them are small flops, so all are
  // cleared by reset; an aborted conversion leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      q        <= '0;
      r        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a    <= din;
            r    <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        DIV1: begin
          r   <= r_step;
          q   <= q_step;
          cnt <= cnt + 3'd1;
          if (last) begin
            // First quotient (<= 25) becomes the dividend of the second pass.
            ones <= r_step[3:0];
            a    <= q_step;
            r    <= '0;
            q    <= '0;
            cnt  <= '0;
          end
        end
        DIV2: begin
          r   <= r_step;
          q   <= q_step;
          cnt <= cnt + 3'd1;
          if (last) begin
            hundreds <= q_step[3:0];
            tens     <= r_step[3:0];
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2dec_seq.sv
// tb_bin2dec_seq
//
// Self-checking bench for bin2dec_seq. A reference model at the posedge
// decides when a request is accepted (the converter is free whenever no
// result is outstanding) and pushes the decimal digits of din into a
// scoreboard. A monitor at the negedge checks busy/done every cycle against
// the outstanding entry and compares digits when done is expected.

module tb_bin2dec_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  bin2dec_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v;
    int h;
    int t;
    int o;
    int acc;  // edge index of the accepting edge
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_acc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a request is taken whenever nothing is outstanding.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      exp_t e;
      cyc++;
      if (start && sb.size() == 0) begin
        e.v   = int'(din);
        e.h   = e.v / 100;
        e.t   = (e.v / 10) % 10;
        e.o   = e.v % 10;
        e.acc = cyc;
        sb.push_back(e);
        n_acc++;
      end
    end
  end

  // Monitor: busy for the 16 cycles after acceptance, done in the 17th.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      bit   exp_b;
      bit   exp_d;
      exp_b = (sb.size() > 0) && (cyc < sb[0].acc + 16);
      exp_d = (sb.size() > 0) && (cyc == sb[0].acc + 16);
      check("busy", int'(busy), int'(exp_b));
      check("done", int'(done), int'(exp_d));
      if (exp_d) begin
        e = sb.pop_front();
        check($sformatf("hundreds(din=%0d)", e.v), int'(hundreds), e.h);
        check($sformatf("tens(din=%0d)", e.v), int'(tens), e.t);
        check($sformatf("ones(din=%0d)", e.v), int'(ones), e.o);
      end
    end
  end

  task automatic issue(input int v);
    start = 1'b1;
    din   = 8'(v);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic check_digits(input string name, input int v);
    check({name, "_h"}, int'(hundreds), v / 100);
    check({name, "_t"}, int'(tens), (v / 10) % 10);
    check({name, "_o"}, int'(ones), v % 10);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(done), 0);
    check_digits(name, 0);
  endtask

  initial begin
    int sweep[4];
    int prev;
    int v;
    sweep = '{0, 97, 100, 255};
    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;

    // Reset state, then idle with start low: nothing moves.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all_zero("idle20");

    // Directed value sweep; digits also hold after done.
    foreach (sweep[i]) begin
      issue(sweep[i]);
      wait_drain(40);
      repeat (3) @(negedge clk);
      check_digits($sformatf("hold%0d", sweep[i]), sweep[i]);
    end

    // Start while busy is ignored.
    issue(128);
    repeat (5) @(negedge clk);
    issue(5);
    wait_drain(40);
    repeat (20) @(negedge clk);
    check_digits("ignored", 128);

    // Back-to-back: start held, din switched after the first acceptance.
    start = 1'b1;
    din   = 8'd42;
    @(negedge clk);
    din   = 8'd199;
    repeat (17) @(negedge clk);
    start = 1'b0;
    wait_drain(40);
    check_digits("b2b", 199);

    // Asynchronous reset in the middle of a conversion.
    issue(255);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all_zero("post_reset");
    issue(9);
    wait_drain(40);

    // Exhaustive back-to-back sweep with start held high.
    for (int x = 0; x < 256; x++) begin
      prev  = n_acc;
      start = 1'b1;
      din   = 8'(x);
      for (int k = 0; k < 40 && n_acc == prev; k++) @(negedge clk);
      check($sformatf("accept_timeout(din=%0d)", x), n_acc - prev, 1);
    end
    start = 1'b0;
    wait_drain(40);

    // Random values with random gaps and stray starts while busy.
    repeat (30) begin
      v = int'($urandom_range(255));
      issue(v);
      repeat ($urandom_range(12)) @(negedge clk);
      if ($urandom_range(1) == 1) issue(int'($urandom_range(255)));
      wait_drain(40);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
